// File: rtl/csi_frame_packer.sv
// rtl/csi_frame_packer.sv - buffers one CSI frame and emits it to DMA behind a 2-word header
// The input is never backpressured; frames that cannot be stored are dropped or discarded and counted.
module csi_frame_packer #(
    parameter int          FRAME_LEN = 64,
    parameter logic [15:0] MAGIC     = 16'hC510
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        csi_axis_tvalid,
    input  logic        csi_axis_tlast,
    input  logic [31:0] csi_axis_tdata,
    output logic        csi_axis_tready,
    output logic        dma_axis_tvalid,
    output logic        dma_axis_tlast,
    output logic [31:0] dma_axis_tdata,
    input  logic        dma_axis_tready
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DISCARD,
        S_SEND_HDR0,
        S_SEND_HDR1,
        S_SEND_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [15:0]        seq_q, seq_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [31:0]        hdr1_q, hdr1_d;
    logic               mid_frame_q, mid_frame_d;
    logic               cause_drop_q, cause_drop_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               mem_we;
    logic               drop_inc, err_inc;
    logic [31:0]        mem [FRAME_LEN];

    logic in_beat, out_beat;

    assign csi_axis_tready = ~rst_in;
    assign in_beat         = csi_axis_tvalid & csi_axis_tready;
    assign out_beat        = out_valid_q & dma_axis_tready;

    assign dma_axis_tvalid = out_valid_q;
    assign dma_axis_tlast  = out_last_q;
    assign dma_axis_tdata  = out_data_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        seq_d        = seq_q;
        hdr1_d       = hdr1_q;
        mid_frame_d  = mid_frame_q;
        cause_drop_d = cause_drop_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        mem_we       = 1'b0;
        drop_inc     = 1'b0;
        err_inc      = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (in_beat) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (csi_axis_tlast) begin
                        wr_idx_d = '0;
                        if (wr_idx_q == LAST_IDX) begin
                            state_d     = S_SEND_HDR0;
                            out_valid_d = 1'b1;
                            out_last_d  = 1'b0;
                            out_data_d  = {MAGIC, seq_q};
                            hdr1_d      = {drop_cnt_q, err_cnt_q};
                            mid_frame_d = 1'b0;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (wr_idx_q == LAST_IDX) begin
                        err_inc      = 1'b1;
                        wr_idx_d     = '0;
                        cause_drop_d = 1'b0;
                        state_d      = S_DISCARD;
                    end
                end
            end

            S_DISCARD: begin
                if (in_beat && csi_axis_tlast) begin
                    drop_inc = cause_drop_q;
                    state_d  = S_COLLECT;
                end
            end

            S_SEND_HDR0, S_SEND_HDR1, S_SEND_DATA: begin
                // Input arriving while the buffer is being drained is thrown away.
                if (in_beat) begin
                    drop_inc    = csi_axis_tlast;
                    mid_frame_d = ~csi_axis_tlast;
                end
                if (out_beat) begin
                    if (state_q == S_SEND_HDR0) begin
                        state_d    = S_SEND_HDR1;
                        out_data_d = hdr1_q;
                    end else if (state_q == S_SEND_HDR1) begin
                        state_d    = S_SEND_DATA;
                        out_data_d = mem[0];
                        out_last_d = 1'b0;
                        rd_idx_d   = IDX_W'(1);
                    end else if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        out_data_d   = '0;
                        rd_idx_d     = '0;
                        seq_d        = seq_q + 16'd1;
                        cause_drop_d = 1'b1;
                        state_d      = mid_frame_d ? S_DISCARD : S_COLLECT;
                    end else begin
                        out_data_d = mem[rd_idx_q];
                        out_last_d = (rd_idx_q == LAST_IDX);
                        rd_idx_d   = rd_idx_q + IDX_W'(1);
                    end
                end
            end

            default: state_d = S_COLLECT;
        endcase

        drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
        err_cnt_d  = sat_inc(err_cnt_q, err_inc);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_COLLECT;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            seq_q        <= '0;
            drop_cnt_q   <= '0;
            err_cnt_q    <= '0;
            hdr1_q       <= '0;
            mid_frame_q  <= 1'b0;
            cause_drop_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            seq_q        <= seq_d;
            drop_cnt_q   <= drop_cnt_d;
            err_cnt_q    <= err_cnt_d;
            hdr1_q       <= hdr1_d;
            mid_frame_q  <= mid_frame_d;
            cause_drop_q <= cause_drop_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[wr_idx_q] <= csi_axis_tdata;
        end
    end

endmodule

// File: tb/tb_csi_frame_packer.sv
// tb/tb_csi_frame_packer.sv - scoreboard bench for csi_frame_packer
module tb_csi_frame_packer;

    localparam logic [15:0] MAGIC = 16'hC510;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csi_tvalid = 1'b0;
    logic        csi_tlast = 1'b0;
    logic [31:0] csi_tdata = '0;
    logic        csi_tready;
    logic        dma_tvalid;
    logic        dma_tlast;
    logic [31:0] dma_tdata;
    logic        fixed_rdy = 1'b1;
    logic        rand_en = 1'b0;
    logic        rnd_bit = 1'b1;
    logic        dma_tready;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pkt_beats = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          tlast_in_cyc = 0;
    logic [32:0] exp_q[$];

    assign dma_tready = rand_en ? rnd_bit : fixed_rdy;

    always #5 clk = ~clk;

    csi_frame_packer dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .csi_axis_tvalid (csi_tvalid),
        .csi_axis_tlast  (csi_tlast),
        .csi_axis_tdata  (csi_tdata),
        .csi_axis_tready (csi_tready),
        .dma_axis_tvalid (dma_tvalid),
        .dma_axis_tlast  (dma_tlast),
        .dma_axis_tdata  (dma_tdata),
        .dma_axis_tready (dma_tready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cycle_counter();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic rand_ready();
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic monitor();
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("csi_tready", 32'(csi_tready), 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(dma_tvalid), 32'd1);
                check("stall_data", dma_tdata, prev_data);
                check("stall_last", 32'(dma_tlast), 32'(prev_last));
            end
            if (dma_tvalid && dma_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_beat: got %h expected no output", dma_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("dma_tdata", dma_tdata, e[31:0]);
                    check("dma_tlast", 32'(dma_tlast), 32'(e[32]));
                    if (pkt_beats == 0) first_cyc = cyc;
                    pkt_beats++;
                    if (e[32]) begin
                        last_cyc  = cyc;
                        pkt_beats = 0;
                    end
                end
            end
            prev_stall = dma_tvalid && !dma_tready;
            prev_data  = dma_tdata;
            prev_last  = dma_tlast;
        end
    endtask

    task automatic push_packet(input logic [15:0] seq, input logic [31:0] hdr1, input logic [31:0] base);
        exp_q.push_back({1'b0, MAGIC, seq});
        exp_q.push_back({1'b0, hdr1});
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 63), base + 32'(i)});
    endtask

    // Leaves the final word on the bus; the next drive call consumes it.
    task automatic send_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            csi_tvalid = 1'b1;
            csi_tdata  = base + 32'(i);
            csi_tlast  = (i == n - 1);
            if (i == n - 1) tlast_in_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            csi_tvalid = 1'b0;
            csi_tlast  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dma_tvalid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, 32'(t < 3000), 32'd1);
        idle(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        csi_tvalid = 1'b0;
        csi_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        fork
            cycle_counter();
            monitor();
            rand_ready();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(dma_tvalid), 32'd0);
        check("rst_tlast", 32'(dma_tlast), 32'd0);
        check("rst_tdata", dma_tdata, 32'd0);
        check("rst_csi_tready", 32'(csi_tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame: latency, contiguity, then sequence advance
        push_packet(16'd0, 32'h0000_0000, 32'd0);
        send_frame(64, 32'd0);
        idle(1);
        wait_drain("drain_single");
        check("hdr0_latency", 32'(first_cyc), 32'(tlast_in_cyc + 1));
        check("no_bubbles", 32'(last_cyc - first_cyc), 32'd65);
        push_packet(16'd1, 32'h0000_0000, 32'h100);
        send_frame(64, 32'h100);
        idle(1);
        wait_drain("drain_seq1");

        // Back-to-back: second frame lands entirely inside the send
        do_reset();
        push_packet(16'd0, 32'h0000_0000, 32'h200);
        send_frame(64, 32'h200);
        send_frame(64, 32'h300);
        idle(10);
        push_packet(16'd1, 32'h0001_0000, 32'h400);
        send_frame(64, 32'h400);
        idle(1);
        wait_drain("drain_b2b");

        // Frame straddling the end of the send is discarded up to its tlast
        do_reset();
        push_packet(16'd0, 32'h0000_0000, 32'h500);
        send_frame(64, 32'h500);
        idle(20);
        send_frame(64, 32'h600);
        idle(10);
        push_packet(16'd1, 32'h0001_0000, 32'h700);
        send_frame(64, 32'h700);
        idle(1);
        wait_drain("drain_straddle");

        // Short frame then good frame
        do_reset();
        send_frame(10, 32'h800);
        push_packet(16'd0, 32'h0000_0001, 32'h900);
        send_frame(64, 32'h900);
        idle(1);
        wait_drain("drain_short");

        // Long frame then good frame
        do_reset();
        send_frame(70, 32'hA00);
        push_packet(16'd0, 32'h0000_0001, 32'hB00);
        send_frame(64, 32'hB00);
        idle(1);
        wait_drain("drain_long");

        // Random downstream stalls
        do_reset();
        rand_en = 1'b1;
        push_packet(16'd0, 32'h0000_0000, 32'hC00);
        send_frame(64, 32'hC00);
        idle(1);
        wait_drain("drain_random");
        rand_en = 1'b0;

        // Reset in the middle of a packet clears seq and counters
        do_reset();
        send_frame(10, 32'hD00);
        push_packet(16'd0, 32'h0000_0001, 32'hE00);
        send_frame(64, 32'hE00);
        idle(1);
        wait_drain("drain_pre_abort");
        push_packet(16'd1, 32'h0000_0001, 32'hF00);
        send_frame(64, 32'hF00);
        idle(1);
        t = 0;
        while (pkt_beats < 22 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_word20", 32'(t < 500), 32'd1);
        check("word20_present", dma_tdata, 32'hF00 + 32'd20);
        rst       = 1'b1;
        fixed_rdy = 1'b0;
        exp_q.delete();
        pkt_beats = 0;
        @(posedge clk);
        #1;
        check("abort_tvalid", 32'(dma_tvalid), 32'd0);
        check("abort_tlast", 32'(dma_tlast), 32'd0);
        check("abort_tdata", dma_tdata, 32'd0);
        rst       = 1'b0;
        fixed_rdy = 1'b1;
        idle(2);
        push_packet(16'd0, 32'h0000_0000, 32'h1000);
        send_frame(64, 32'h1000);
        idle(1);
        wait_drain("drain_post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/csi_frame_packer.md
Name: csi_frame_packer

Overview:
- Sits directly downstream of the CSI extractor's equalizer output; consumes the per-packet CSI stream (FRAME_LEN words, tlast on the final word).
- Buffers one complete frame, then emits it toward the DMA with a 2-word header: magic/sequence number, then drop/error counters.
- Never backpressures the CSI pipeline. Frames arriving while a frame is being sent are dropped and counted; malformed frames are discarded and counted.

Parameters:
FRAME_LEN  64  CSI words per frame; power of two, 4..1024
MAGIC  16'hC510  constant in header word 0 [31:16]

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
csi_axis_tvalid  input  1  CSI word valid
csi_axis_tlast  input  1  last CSI word of frame
csi_axis_tdata  input  32  CSI word {re[15:0], im[15:0]}, passed through unmodified
csi_axis_tready  output  1  always 1 outside reset
dma_axis_tvalid  output  1  output word valid
dma_axis_tlast  output  1  last word of packet
dma_axis_tdata  output  32  header or CSI word
dma_axis_tready  input  1  downstream ready

Behaviour:
- Reset:
  - dma_axis_tvalid=0, dma_axis_tlast=0, dma_axis_tdata=0.
  - csi_axis_tready=0 while rst_in=1, else 1.
  - State=COLLECT; wr_idx, seq, drop_cnt and err_cnt all cleared to 0.
  - Reset mid-packet aborts the packet immediately; no tlast is issued.
- Input beat = csi_axis_tvalid & csi_axis_tready.
- Output beat = dma_axis_tvalid & dma_axis_tready. While tvalid=1 and tready=0, tdata and tlast hold stable.
- COLLECT: on each beat, write mem[wr_idx] and increment wr_idx.
  - tlast=1 and wr_idx==FRAME_LEN-1: frame complete -> SEND_HDR0; wr_idx=0.
  - tlast=1 and wr_idx<FRAME_LEN-1 (short frame): err_cnt++; wr_idx=0; stay in COLLECT.
  - tlast=0 and wr_idx==FRAME_LEN-1 (long frame): err_cnt++; wr_idx=0; -> DISCARD with cause=ERR.
- DISCARD: drop beats until a tlast beat, then -> COLLECT.
  - If cause=DROP, that tlast increments drop_cnt.
- SEND_HDR0: dma_axis_tvalid rises the cycle after entry.
  - tdata={MAGIC, seq}. After the output beat -> SEND_HDR1.
- SEND_HDR1: tdata={drop_cnt, err_cnt}, sampled on entry to SEND_HDR0. After the output beat -> SEND_DATA.
- SEND_DATA: emit mem[0..FRAME_LEN-1] in order; tlast=1 only on mem[FRAME_LEN-1].
  - Sustains 1 word/cycle while tready=1 (read-ahead required); no bubbles between header and data.
  - After the final output beat: seq++ (wraps at 16 bits); tvalid=0 the next cycle.
- Input during SEND_* states: accepted and discarded.
  - Each tlast beat increments drop_cnt.
  - A track flag mid_frame is set on a non-tlast beat and cleared on a tlast beat.
  - On leaving SEND_DATA: mid_frame=1 -> DISCARD with cause=DROP; else -> COLLECT.
  - An input beat in the same cycle as the final output beat is treated as received during SEND.
- Counters:
  - drop_cnt and err_cnt are 16-bit, saturate at 0xFFFF, and are cumulative (cleared only by reset).
  - An increment coinciding with the header snapshot appears in the next packet.
- Latency: from the completing tlast input beat to HDR0 tvalid is 1 cycle. Packet length is FRAME_LEN+2 words.

Test Plan:
- Single 64-word frame, data=i, tready=1 -> 66 contiguous words: 0xC5100000, 0x00000000, 0..63; tlast only on 63; next packet has seq=1.
- Back-to-back frames, tready=1 -> first sent; second frame (arrives during send) dropped; third frame sent with HDR0=0xC5100001, HDR1=0x00010000.
- Short frame (tlast at word 10), then a good frame -> good packet has HDR1=0x00000001; data intact.
- Long frame (70 words, tlast on 70th), then a good frame -> err_cnt=1; extra words discarded; next frame packed correctly starting at its word 0.
- Random tready (~50%) on a full frame -> data and tlast stable under stall; order preserved; csi_axis_tready stays 1 throughout.
- rst_in asserted at data word 20 of a packet -> next cycle tvalid=0 and counters 0; the following frame emits seq=0.
